bus_mem_responder: RTL and testbench
====================================

# bus_mem_responder

Single-clock on-chip memory that serves the frame-buffer bus as the responder. It accepts word writes and reads from the DRAM-side controller using a hold-until-acknowledged waitrequest protocol. It arbitrates between the write and read channels into one single-port RAM and returns read data with a configurable latency. It stands in for the external memory system in block-level and FPGA bring-up builds.

## Interface
- DEPTH, 17: words of storage; covers byte addresses 0..(DEPTH-1)*4.
- ADDR_W, 5: word-index width; must satisfy 2^ADDR_W >= DEPTH.
- READ_LAT, 2: cycles from read grant to read acknowledge; legal range 1..15.
- ctrl_clk  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- write_addr  in  32  byte address of the write; bits [1:0] ignored.
- iData  in  32  write data.
- write  in  1  write request; held by the master until acknowledged.
- write_waitrequest  out  1  low for exactly one cycle = write accepted.
- read_addr  in  32  byte address of the read; bits [1:0] ignored.
- read  in  1  read request; held by the master until acknowledged.
- oData  out  32  read data; valid in the cycle read_waitrequest is low.
- read_waitrequest  out  1  low for exactly one cycle = read data valid.
- wr_count  out  16  committed write count (see Configuration).
- rd_count  out  16  acknowledged read count (see Configuration).
- oor_count  out  16  out-of-range access count (see Configuration).

## Operation
- States: IDLE, WR_ACK, RD_WAIT, RD_ACK.
- All outputs are registered. Reset values:
  - state = IDLE
  - both waitrequests = 1
  - oData = 0
  - all counters = 0
  - last_grant = READ
- IDLE transitions:
  - write only: grant write; capture write_addr and iData; go to WR_ACK.
  - read only: grant read; capture read_addr. Go to RD_WAIT if READ_LAT > 1, otherwise RD_ACK.
  - both: grant the channel opposite to last_grant, then update last_grant. After reset, write wins first.
- WR_ACK:
  - write_waitrequest = 0.
  - RAM written at the end of this cycle from the captured address and data.
  - Next state: IDLE.
- RD_WAIT: counts READ_LAT-1 cycles, then goes to RD_ACK. The RAM is read from the captured address.
- RD_ACK:
  - read_waitrequest = 0; oData holds the word.
  - Next state: IDLE.
  - oData keeps its value until the next RD_ACK.
- Word index = addr[ADDR_W+1:2]. An address is out of range when the index is >= DEPTH, or when any bit of addr[31:ADDR_W+2] is nonzero.
  - Out-of-range write: acknowledged normally, RAM untouched.
  - Out-of-range read: acknowledged normally, oData = 0.
- Request dropped before its acknowledge (abort):
  - The transaction completes internally and returns to IDLE.
  - No acknowledge is issued.
  - An aborted write still commits.
  - Counters do not increment.
- RAM contents are not cleared by reset. Reading a location that was never written returns an undefined value.
- A reset asserted mid-transaction forces IDLE immediately. A pending write in WR_ACK is not committed.

## Timing
- Grant cycle T is an IDLE cycle with a request present.
- Write acknowledge at T+1. Read acknowledge at T+READ_LAT.
- The earliest next grant is at T+2 after a write, and at T+READ_LAT+1 after a read.
- Read-after-write: a write acknowledged at cycle W is visible to any read granted at W+1 or later.
- Sustained single-channel throughput:
  - writes: one per 2 cycles;
  - reads: one per READ_LAT+1 cycles.
- Waitrequest never glitches low outside an ACK state, and is never low on both channels in the same cycle.

## Configuration
- BUS_RESP_STATS_EN defined:
  - wr_count increments on each acknowledged write; rd_count on each acknowledged read.
  - oor_count increments on each acknowledged out-of-range access.
  - All counters saturate at 16'hFFFF.
- Not defined: all three counters are tied to 0 and no counter logic is synthesized.
- Protocol behaviour is identical in both builds.

## Test plan
- Single write: addr 0x8, data 0xDEADBEEF granted at T → write_waitrequest low at T+1 only. A later read of 0x8 returns 0xDEADBEEF with read_waitrequest low at grant+2 (READ_LAT=2).
- Full frame: write words 0..16 (addr 0..0x40) with data = index×3, then read all back → every word matches. With the macro, wr_count=17 and rd_count=17.
- Simultaneous requests: write and read both held from reset → order of grants is write, read, write, read. No cycle has both waitrequests low.
- Out of range: write 0x55 to addr 0x44, then read 0x44 → both acknowledged, oData=0, oor_count=2. Word 0x40 is unchanged.
- Abort and reset: read dropped during RD_WAIT → no acknowledge, rd_count unchanged. reset_n pulsed low while in WR_ACK → target word unchanged, all outputs at their reset values.
- READ_LAT=1 build: back-to-back reads at addr 0x0 and 0x4 → acknowledges 2 cycles apart, oData correct in each acknowledge cycle.

Source files
------------

// File: rtl/bus_mem_responder.sv
// Single-port word memory responding to the frame-buffer bus with waitrequest handshakes.
// Optional statistics counters are built when BUS_RESP_STATS_EN is defined.
module bus_mem_responder #(
    parameter int DEPTH    = 17,
    parameter int ADDR_W   = 5,
    parameter int READ_LAT = 2
) (
    input  logic        ctrl_clk,
    input  logic        reset_n,
    input  logic [31:0] write_addr,
    input  logic [31:0] iData,
    input  logic        write,
    output logic        write_waitrequest,
    input  logic [31:0] read_addr,
    input  logic        read,
    output logic [31:0] oData,
    output logic        read_waitrequest,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count,
    output logic [15:0] oor_count
);

    typedef enum logic [1:0] {IDLE, WR_ACK, RD_WAIT, RD_ACK} state_t;

    localparam int          LAT_INIT_I = (READ_LAT > 1) ? READ_LAT - 2 : 0;
    localparam logic [3:0]  LAT_INIT   = LAT_INIT_I[3:0];

    function automatic logic is_oor(input logic [31:0] a);
        return (a[31:ADDR_W+2] != '0) || (int'(a[ADDR_W+1:2]) >= DEPTH);
    endfunction

    state_t              state_q, state_d;
    logic                last_wr_q, last_wr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                oor_q, oor_d;
    logic [31:0]         data_q, data_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                abort_q, abort_d;
    logic                wr_wait_q, wr_wait_d;
    logic                rd_wait_q, rd_wait_d;
    logic [31:0]         odata_q, odata_d;

    logic [31:0]         mem [DEPTH];
    logic [ADDR_W-1:0]   rd_idx;
    logic                rd_oor;
    logic [31:0]         rd_word;

    logic                unused_addr_lsbs;
    assign unused_addr_lsbs = ^{write_addr[1:0], read_addr[1:0]};

    // In IDLE the read port looks at the incoming address so a single-cycle latency works
    always_comb begin
        rd_idx  = (state_q == IDLE) ? read_addr[ADDR_W+1:2] : idx_q;
        rd_oor  = (state_q == IDLE) ? is_oor(read_addr) : oor_q;
        rd_word = rd_oor ? 32'd0 : mem[rd_idx];
    end

    always_ff @(posedge ctrl_clk) begin
        if (state_q == WR_ACK && !oor_q) begin
            mem[idx_q] <= data_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        idx_d     = idx_q;
        oor_d     = oor_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        wr_wait_d = 1'b1;
        rd_wait_d = 1'b1;
        odata_d   = odata_q;
        case (state_q)
            IDLE: begin
                if (write && (!read || !last_wr_q)) begin
                    idx_d     = write_addr[ADDR_W+1:2];
                    oor_d     = is_oor(write_addr);
                    data_d    = iData;
                    last_wr_d = 1'b1;
                    wr_wait_d = 1'b0;
                    state_d   = WR_ACK;
                end else if (read) begin
                    idx_d     = read_addr[ADDR_W+1:2];
                    oor_d     = rd_oor;
                    last_wr_d = 1'b0;
                    abort_d   = 1'b0;
                    cnt_d     = LAT_INIT;
                    if (READ_LAT > 1) begin
                        state_d = RD_WAIT;
                    end else begin
                        state_d   = RD_ACK;
                        rd_wait_d = 1'b0;
                        odata_d   = rd_word;
                    end
                end
            end
            WR_ACK: state_d = IDLE;
            RD_WAIT: begin
                // A dropped request is remembered so the transaction finishes silently
                if (!read) begin
                    abort_d = 1'b1;
                end
                if (cnt_q == 4'd0) begin
                    state_d = RD_ACK;
                    if (read && !abort_q) begin
                        rd_wait_d = 1'b0;
                        odata_d   = rd_word;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ctrl_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
            idx_q     <= '0;
            oor_q     <= 1'b0;
            data_q    <= '0;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            wr_wait_q <= 1'b1;
            rd_wait_q <= 1'b1;
            odata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            idx_q     <= idx_d;
            oor_q     <= oor_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
            wr_wait_q <= wr_wait_d;
            rd_wait_q <= rd_wait_d;
            odata_q   <= odata_d;
        end
    end

    assign write_waitrequest = wr_wait_q;
    assign read_waitrequest  = rd_wait_q;
    assign oData             = odata_q;

`ifdef BUS_RESP_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] oor_cnt_q, oor_cnt_d;

    // Counting happens in the acknowledge cycle, so aborted transfers never count
    always_comb begin
        wr_cnt_d  = sat_inc(wr_cnt_q, !wr_wait_q);
        rd_cnt_d  = sat_inc(rd_cnt_q, !rd_wait_q);
        oor_cnt_d = sat_inc(oor_cnt_q, (!wr_wait_q || !rd_wait_q) && oor_q);
    end

    always_ff @(posedge ctrl_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            oor_cnt_q <= '0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            oor_cnt_q <= oor_cnt_d;
        end
    end

    assign wr_count  = wr_cnt_q;
    assign rd_count  = rd_cnt_q;
    assign oor_count = oor_cnt_q;
`else
    assign wr_count  = 16'd0;
    assign rd_count  = 16'd0;
    assign oor_count = 16'd0;
`endif

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed self-checking bench for bus_mem_responder (READ_LAT=2 main instance, READ_LAT=1 second instance).
module tb_bus_mem_responder;

`ifdef BUS_RESP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        ctrl_clk;
    logic        reset_n;
    logic [31:0] write_addr, iData, read_addr, oData;
    logic        write, read, write_waitrequest, read_waitrequest;
    logic [15:0] wr_count, rd_count, oor_count;

    logic [31:0] wa1, wd1, ra1, od1;
    logic        w1, r1, wwr1, rwr1;
    logic [15:0] wc1, rc1, oc1;

    int checks = 0;
    int errors = 0;

    bus_mem_responder #(.DEPTH(17), .ADDR_W(5), .READ_LAT(2)) dut (
        .ctrl_clk(ctrl_clk), .reset_n(reset_n),
        .write_addr(write_addr), .iData(iData), .write(write),
        .write_waitrequest(write_waitrequest),
        .read_addr(read_addr), .read(read), .oData(oData),
        .read_waitrequest(read_waitrequest),
        .wr_count(wr_count), .rd_count(rd_count), .oor_count(oor_count)
    );

    bus_mem_responder #(.DEPTH(17), .ADDR_W(5), .READ_LAT(1)) dut1 (
        .ctrl_clk(ctrl_clk), .reset_n(reset_n),
        .write_addr(wa1), .iData(wd1), .write(w1),
        .write_waitrequest(wwr1),
        .read_addr(ra1), .read(r1), .oData(od1),
        .read_waitrequest(rwr1),
        .wr_count(wc1), .rd_count(rc1), .oor_count(oc1)
    );

    initial ctrl_clk = 1'b0;
    always #5 ctrl_clk = ~ctrl_clk;

    task automatic tick();
        @(posedge ctrl_clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Issues one write from IDLE; lat = edges until ack (-1 on timeout), post = waitrequest one cycle later
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, output int lat, output logic post);
        write_addr = a;
        iData = d;
        write = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (!write_waitrequest) begin
                lat = i;
                break;
            end
        end
        write = 1'b0;
        tick();
        post = write_waitrequest;
    endtask

    task automatic do_read(input logic [31:0] a, output int lat, output logic [31:0] d, output logic post);
        read_addr = a;
        read = 1'b1;
        lat = -1;
        d = 32'hx;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (!read_waitrequest) begin
                lat = i;
                d = oData;
                break;
            end
        end
        read = 1'b0;
        tick();
        post = read_waitrequest;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks += 5;
        if (write_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wr_wait got %b want 1", write_waitrequest); end
        if (read_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_rd_wait got %b want 1", read_waitrequest); end
        if (oData !== 32'd0) begin errors++; $display("FAIL reset_odata got %h want 0", oData); end
        if (wr_count !== 16'd0 || rd_count !== 16'd0) begin errors++; $display("FAIL reset_wr_rd_count got %0d/%0d want 0/0", wr_count, rd_count); end
        if (oor_count !== 16'd0) begin errors++; $display("FAIL reset_oor_count got %0d want 0", oor_count); end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        int lat;
        logic post;
        logic [31:0] d;
        do_write(32'h8, 32'hDEADBEEF, lat, post);
        checks += 2;
        if (lat !== 1) begin errors++; $display("FAIL single_wr_lat got %0d want 1", lat); end
        if (post !== 1'b1) begin errors++; $display("FAIL single_wr_ack_width got %b want 1", post); end
        do_read(32'h8, lat, d, post);
        checks += 3;
        if (lat !== 2) begin errors++; $display("FAIL single_rd_lat got %0d want 2", lat); end
        if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rd_data got %h want deadbeef", d); end
        if (post !== 1'b1) begin errors++; $display("FAIL single_rd_ack_width got %b want 1", post); end
    endtask

    task automatic test_full_frame();
        int lat;
        logic post;
        logic [31:0] d;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            do_write(32'(i * 4), 32'(i * 3), lat, post);
        end
        for (int i = 0; i < 17; i++) begin
            do_read(32'(i * 4), lat, d, post);
            checks++;
            if (d !== 32'(i * 3)) begin errors++; $display("FAIL frame_word%0d got %h want %h", i, d, 32'(i * 3)); end
        end
        checks += 2;
        if (wr_count !== (STATS ? 16'd17 : 16'd0)) begin errors++; $display("FAIL frame_wr_count got %0d", wr_count); end
        if (rd_count !== (STATS ? 16'd17 : 16'd0)) begin errors++; $display("FAIL frame_rd_count got %0d", rd_count); end
    endtask

    task automatic test_out_of_range();
        int lat;
        logic post;
        logic [31:0] d;
        apply_reset();
        do_read(32'h40, lat, d, post);
        do_write(32'h44, 32'h55, lat, post);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL oor_wr_ack got lat %0d want 1", lat); end
        do_read(32'h44, lat, d, post);
        checks += 3;
        if (lat !== 2) begin errors++; $display("FAIL oor_rd_ack got lat %0d want 2", lat); end
        if (d !== 32'd0) begin errors++; $display("FAIL oor_rd_data got %h want 0", d); end
        if (oor_count !== (STATS ? 16'd2 : 16'd0)) begin errors++; $display("FAIL oor_count got %0d", oor_count); end
        do_read(32'h1000_0008, lat, d, post);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL oor_high_bits_data got %h want 0", d); end
        do_read(32'h40, lat, d, post);
        checks++;
        if (d !== 32'd48) begin errors++; $display("FAIL oor_word16_kept got %h want 30", d); end
    endtask

    task automatic test_simultaneous();
        byte order [4];
        int n = 0;
        int both_low = 0;
        reset_n = 1'b0;
        write_addr = 32'h0;
        iData = 32'h77;
        read_addr = 32'h4;
        write = 1'b1;
        read = 1'b1;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 30 && n < 4; i++) begin
            tick();
            if (!write_waitrequest && !read_waitrequest) both_low++;
            if (!write_waitrequest) begin order[n] = "W"; n++; end
            else if (!read_waitrequest) begin order[n] = "R"; n++; end
        end
        write = 1'b0;
        read = 1'b0;
        tick();
        checks += 2;
        if (n !== 4) begin errors++; $display("FAIL arb_ack_count got %0d want 4", n); end
        if (both_low !== 0) begin errors++; $display("FAIL arb_both_low got %0d want 0", both_low); end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (order[k] !== ((k % 2 == 0) ? "W" : "R")) begin
                errors++; $display("FAIL arb_order%0d got %c want %c", k, order[k], (k % 2 == 0) ? "W" : "R");
            end
        end
    endtask

    task automatic test_abort_and_reset();
        int acks = 0;
        int lat;
        logic post;
        logic [31:0] d;
        apply_reset();
        read_addr = 32'h8;
        read = 1'b1;
        tick();
        read = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!read_waitrequest) acks++;
        end
        checks += 2;
        if (acks !== 0) begin errors++; $display("FAIL abort_ack got %0d acks want 0", acks); end
        if (rd_count !== 16'd0) begin errors++; $display("FAIL abort_rd_count got %0d want 0", rd_count); end
        do_read(32'h8, lat, d, post);
        checks += 2;
        if (lat !== 2) begin errors++; $display("FAIL abort_recover_lat got %0d want 2", lat); end
        if (d !== 32'd6) begin errors++; $display("FAIL abort_recover_data got %h want 6", d); end

        write_addr = 32'h10;
        iData = 32'hBAD;
        write = 1'b1;
        tick();
        checks++;
        if (write_waitrequest !== 1'b0) begin errors++; $display("FAIL rstwr_in_ack got %b want 0", write_waitrequest); end
        reset_n = 1'b0;
        #1;
        checks += 4;
        if (write_waitrequest !== 1'b1) begin errors++; $display("FAIL rstwr_wr_wait got %b want 1", write_waitrequest); end
        if (read_waitrequest !== 1'b1) begin errors++; $display("FAIL rstwr_rd_wait got %b want 1", read_waitrequest); end
        if (oData !== 32'd0) begin errors++; $display("FAIL rstwr_odata got %h want 0", oData); end
        if (wr_count !== 16'd0 || rd_count !== 16'd0 || oor_count !== 16'd0) begin
            errors++; $display("FAIL rstwr_counts got %0d/%0d/%0d want 0", wr_count, rd_count, oor_count);
        end
        write = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        do_read(32'h10, lat, d, post);
        checks++;
        if (d !== 32'd12) begin errors++; $display("FAIL rstwr_word_kept got %h want c", d); end
    endtask

    task automatic dut1_write(input logic [31:0] a, input logic [31:0] d);
        wa1 = a;
        wd1 = d;
        w1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!wwr1) break;
        end
        w1 = 1'b0;
        tick();
    endtask

    task automatic test_lat1_back_to_back();
        int ack_cyc [2];
        logic [31:0] ack_dat [2];
        int n = 0;
        dut1_write(32'h0, 32'h1111_0000);
        dut1_write(32'h4, 32'h2222_0001);
        ra1 = 32'h0;
        r1 = 1'b1;
        for (int c = 1; c <= 20 && n < 2; c++) begin
            tick();
            if (!rwr1) begin
                ack_cyc[n] = c;
                ack_dat[n] = od1;
                n++;
                ra1 = 32'h4;
            end
        end
        r1 = 1'b0;
        tick();
        checks++;
        if (n !== 2) begin
            errors++; $display("FAIL lat1_acks got %0d want 2", n);
        end else begin
            checks += 4;
            if (ack_cyc[0] !== 1) begin errors++; $display("FAIL lat1_first_lat got %0d want 1", ack_cyc[0]); end
            if (ack_cyc[1] - ack_cyc[0] !== 2) begin errors++; $display("FAIL lat1_spacing got %0d want 2", ack_cyc[1] - ack_cyc[0]); end
            if (ack_dat[0] !== 32'h1111_0000) begin errors++; $display("FAIL lat1_data0 got %h want 11110000", ack_dat[0]); end
            if (ack_dat[1] !== 32'h2222_0001) begin errors++; $display("FAIL lat1_data1 got %h want 22220001", ack_dat[1]); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        write = 1'b0; read = 1'b0;
        write_addr = '0; iData = '0; read_addr = '0;
        w1 = 1'b0; r1 = 1'b0;
        wa1 = '0; wd1 = '0; ra1 = '0;
        test_reset();
        test_single();
        test_full_frame();
        test_out_of_range();
        test_simultaneous();
        test_abort_and_reset();
        test_lat1_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
